// File: rtl/uart_tx.sv
// uart_tx: 8E1 serial transmitter (start, 8 data LSB first, even parity, stop)
// fed from a small write-side FIFO. Bit timing comes from the one-clk baud
// tick bclk_tx; the line only changes on clk edges where that tick is high.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bclk_tx,
  input  logic              wr_en,
  input  logic [7:0]        d_in,
  output logic              full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              busy,
  output logic              overflow,
  output logic              tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic              parity;
  logic              push;
  logic              pop;

  // full and the pop decision both use the pre-edge count, so a write that
  // lands in the same cycle as a pop from a full FIFO is still rejected, and
  // a byte written on the launching tick into an empty FIFO waits a tick.
  assign full = (fifo_count == DEPTH_CNT);
  assign push = wr_en && !full;
  assign pop  = bclk_tx && ((state == IDLE) || (state == STOP)) && (fifo_count != '0);

  // FIFO storage; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer: advances one bit per baud tick, launching the next queued
  // byte straight out of STOP so consecutive frames run back to back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
      parity  <= 1'b0;
    end else if (bclk_tx) begin
      case (state)
        IDLE, STOP: begin
          if (pop) begin
            shift  <= mem[rd_ptr];
            parity <= ^mem[rd_ptr];
            tx     <= 1'b0;
            busy   <= 1'b1;
            state  <= START;
          end else begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        START: begin
          tx      <= shift[0];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt != 3'd7) begin
            shift   <= {1'b0, shift[7:1]};
            tx      <= shift[1];
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            tx    <= parity;
            state <= PARITY;
          end
        end
        PARITY: begin
          tx    <= 1'b1;
          state <= STOP;
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
